// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared types, constants and helpers for the N-user priority arbiter
package arbitro_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        COOLDOWN  = 2'd2,
        AUTOPILOT = 2'd3
    } estado_t;

    // Function code meaning "no request"
    localparam int FUNC_NEUTRO = 0;

    // True when the low `width` bits of code are all ones (the autopilot user code)
    function automatic logic is_autopilot_code(input logic [31:0] code, input int unsigned width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (code & mask) == mask;
    endfunction

endpackage

// File: rtl/arbitro_seletor.sv
// rtl/arbitro_seletor.sv - combinational per-function winner selection with round-robin tie break
module arbitro_seletor
#(
    parameter int N_USERS = 4,
    parameter int USER_W  = 3,
    parameter int FUNC_W  = 3,
    parameter int RR_W    = 2
)
(
    input  logic [N_USERS-1:0]        valid,
    input  logic [N_USERS*USER_W-1:0] codes,
    input  logic [N_USERS*FUNC_W-1:0] funcs,
    input  logic [RR_W-1:0]           rr_ptr,
    output logic [N_USERS-1:0]        grant_next,
    output logic [N_USERS-1:0]        tie_mask,
    output logic                      conflict_next
);

    // Each active user must beat every same-function rival: higher code, or equal code and closer to rr_ptr
    always_comb begin
        logic [USER_W-1:0] ci;
        logic [USER_W-1:0] cj;
        logic [FUNC_W-1:0] fi;
        logic [FUNC_W-1:0] fj;
        logic              win;
        logic              tie;
        int                di;
        int                dj;
        grant_next    = '0;
        tie_mask      = '0;
        conflict_next = 1'b0;
        for (int i = 0; i < N_USERS; i++) begin
            ci  = codes[i*USER_W +: USER_W];
            fi  = funcs[i*FUNC_W +: FUNC_W];
            di  = (i - int'(rr_ptr) + N_USERS) % N_USERS;
            win = valid[i];
            tie = 1'b0;
            for (int j = 0; j < N_USERS; j++) begin
                cj = codes[j*USER_W +: USER_W];
                fj = funcs[j*FUNC_W +: FUNC_W];
                dj = (j - int'(rr_ptr) + N_USERS) % N_USERS;
                if (j != i && valid[i] && valid[j] && fj == fi) begin
                    conflict_next = 1'b1;
                    if (cj == ci) begin
                        tie = 1'b1;
                        if (dj < di) begin
                            win = 1'b0;
                        end
                    end else if (cj > ci) begin
                        win = 1'b0;
                    end
                end
            end
            grant_next[i] = win;
            tie_mask[i]   = win && tie;
        end
    end

endmodule

// File: rtl/arbitro_prioridade_n.sv
// rtl/arbitro_prioridade_n.sv - sequential N-user priority arbiter; ARB_PERMISSAO_EN adds permission check and denied port
module arbitro_prioridade_n
    import arbitro_pkg::*;
#(
    parameter int N_USERS     = 4,
    parameter int USER_W      = 3,
    parameter int FUNC_W      = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int AP_CYCLES   = 4
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_USERS-1:0]        req_valid,
    input  logic [N_USERS*USER_W-1:0] user_code,
    input  logic [N_USERS*FUNC_W-1:0] func_code,
    output logic [N_USERS-1:0]        grant,
    output logic                      busy,
    output logic                      conflict,
    output logic                      autopilot,
    output logic [USER_W-1:0]         lowest_user
`ifdef ARB_PERMISSAO_EN
   ,output logic [N_USERS-1:0]        denied
`endif
);

    localparam int RR_W   = (N_USERS > 1) ? $clog2(N_USERS) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int AP_W   = $clog2(AP_CYCLES + 1);

    estado_t             state;
    logic [RR_W-1:0]     rr_ptr;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [AP_W-1:0]     ap_cnt;

    logic [N_USERS-1:0]  active;
    logic [N_USERS-1:0]  viol;
    logic                all_ap;
    int                  n_active;
    logic                qualifying;
    logic                ap_exit;
    logic [N_USERS-1:0]  grant_next;
    logic [N_USERS-1:0]  tie_mask;
    logic                conflict_next;
    logic [N_USERS-1:0]  grant_keep;
    logic [RR_W-1:0]     rr_next;
    logic [USER_W-1:0]   low_next;
    logic [USER_W-1:0]   low_keep;

    // Smallest user code among the users selected by mask; 0 when the mask is empty
    function automatic logic [USER_W-1:0] min_code(input logic [N_USERS-1:0] mask,
                                                   input logic [N_USERS*USER_W-1:0] codes);
        logic [USER_W-1:0] m;
        m = '1;
        for (int i = 0; i < N_USERS; i++) begin
            if (mask[i] && codes[i*USER_W +: USER_W] < m) begin
                m = codes[i*USER_W +: USER_W];
            end
        end
        return (mask == '0) ? '0 : m;
    endfunction

    // Classify requesters: active set, permission violations and the autopilot qualification
    always_comb begin
        logic [FUNC_W-1:0] f;
        logic [USER_W-1:0] c;
        active   = '0;
        viol     = '0;
        all_ap   = 1'b1;
        n_active = 0;
        for (int i = 0; i < N_USERS; i++) begin
            f = func_code[i*FUNC_W +: FUNC_W];
            c = user_code[i*USER_W +: USER_W];
            active[i] = req_valid[i] && (f != FUNC_W'(FUNC_NEUTRO));
`ifdef ARB_PERMISSAO_EN
            viol[i]   = active[i] && (32'(f) > 32'(c));
            active[i] = active[i] && !viol[i];
`endif
            if (active[i]) begin
                n_active = n_active + 1;
                if (!is_autopilot_code(32'(c), USER_W)) begin
                    all_ap = 1'b0;
                end
            end
        end
        qualifying = (n_active >= 2) && all_ap;
        ap_exit    = (n_active == 0) || !all_ap;
    end

    arbitro_seletor #(
        .N_USERS (N_USERS),
        .USER_W  (USER_W),
        .FUNC_W  (FUNC_W),
        .RR_W    (RR_W)
    ) u_seletor (
        .valid         (active),
        .codes         (user_code),
        .funcs         (func_code),
        .rr_ptr        (rr_ptr),
        .grant_next    (grant_next),
        .tie_mask      (tie_mask),
        .conflict_next (conflict_next)
    );

    // Derived next values: surviving grants, new round-robin pointer, lowest-code summaries
    always_comb begin
        int last;
        last = 0;
        for (int i = 0; i < N_USERS; i++) begin
            if (tie_mask[i]) begin
                last = i;
            end
        end
        rr_next    = RR_W'((last + 1) % N_USERS);
        grant_keep = grant & req_valid;
        low_next   = min_code(grant_next, user_code);
        low_keep   = min_code(grant_keep, user_code);
    end

    // Arbiter FSM with counters and registered outputs; autopilot entry overrides every other state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            ap_cnt      <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            conflict    <= 1'b0;
            autopilot   <= 1'b0;
            lowest_user <= '0;
`ifdef ARB_PERMISSAO_EN
            denied      <= '0;
`endif
        end else begin
            conflict <= 1'b0;
`ifdef ARB_PERMISSAO_EN
            denied   <= '0;
`endif
            if (!qualifying) begin
                ap_cnt <= '0;
            end else if (ap_cnt != AP_W'(AP_CYCLES)) begin
                ap_cnt <= ap_cnt + 1'b1;
            end

            if (state != AUTOPILOT && ap_cnt == AP_W'(AP_CYCLES)) begin
                state       <= AUTOPILOT;
                grant       <= '0;
                busy        <= 1'b0;
                autopilot   <= 1'b1;
                lowest_user <= '0;
                hold_cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
`ifdef ARB_PERMISSAO_EN
                        denied <= viol;
`endif
                        if (grant_next != '0) begin
                            state       <= GRANT;
                            grant       <= grant_next;
                            busy        <= 1'b1;
                            conflict    <= conflict_next;
                            lowest_user <= low_next;
                            hold_cnt    <= HOLD_W'(1);
                            if (tie_mask != '0) begin
                                rr_ptr <= rr_next;
                            end
                        end
                    end
                    GRANT: begin
                        if (grant_keep == '0 || hold_cnt == HOLD_W'(HOLD_CYCLES)) begin
                            state       <= COOLDOWN;
                            grant       <= '0;
                            busy        <= 1'b0;
                            lowest_user <= '0;
                            hold_cnt    <= '0;
                        end else begin
                            grant    <= grant_keep;
                            hold_cnt <= hold_cnt + 1'b1;
                            if (grant_keep != grant) begin
                                lowest_user <= low_keep;
                            end
                        end
                    end
                    COOLDOWN: begin
                        state <= IDLE;
                    end
                    AUTOPILOT: begin
                        if (ap_exit) begin
                            state     <= IDLE;
                            autopilot <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arbitro_prioridade_n.sv
// tb/tb_arbitro_prioridade_n.sv - scoreboard bench for arbitro_prioridade_n
module tb_arbitro_prioridade_n;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [11:0] user_code;
    logic [11:0] func_code;
    logic [3:0]  grant;
    logic        busy;
    logic        conflict;
    logic        autopilot;
    logic [2:0]  lowest_user;
`ifdef ARB_PERMISSAO_EN
    logic [3:0]  denied;
`endif

    int checks;
    int failures;

    typedef struct {
        logic [3:0] grant;
        logic       conflict;
        logic [2:0] lowest;
    } exp_t;

    exp_t exp_q[$];
    logic ap_q[$];

    arbitro_prioridade_n dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .user_code   (user_code),
        .func_code   (func_code),
        .grant       (grant),
        .busy        (busy),
        .conflict    (conflict),
        .autopilot   (autopilot),
        .lowest_user (lowest_user)
`ifdef ARB_PERMISSAO_EN
       ,.denied      (denied)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_user(input int i, input logic v, input logic [2:0] code, input logic [2:0] func);
        req_valid[i]          = v;
        user_code[i*3 +: 3]   = code;
        func_code[i*3 +: 3]   = func;
    endtask

    task automatic clear_all();
        req_valid = '0;
        user_code = '0;
        func_code = '0;
    endtask

    task automatic wait_idle();
        clear_all();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_all();
        repeat (2) tick();
        checks++;
        if ({grant, busy, conflict, autopilot, lowest_user} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0", {grant, busy, conflict, autopilot, lowest_user});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_priority();
        exp_t e;
        set_user(0, 1'b1, 3'd5, 3'd1);
        set_user(1, 1'b1, 3'd1, 3'd1);
        exp_q.push_back('{grant: 4'b0001, conflict: 1'b1, lowest: 3'd5});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || conflict !== e.conflict || lowest_user !== e.lowest || busy !== 1'b1) begin
            failures++;
            $display("FAIL priority grant=%b conflict=%b lowest=%0d busy=%b want %b %b %0d 1",
                     grant, conflict, lowest_user, busy, e.grant, e.conflict, e.lowest);
        end
        exp_q.push_back('{grant: 4'b0001, conflict: 1'b0, lowest: 3'd5});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || conflict !== e.conflict || lowest_user !== e.lowest) begin
            failures++;
            $display("FAIL priority_hold grant=%b conflict=%b lowest=%0d want %b %b %0d",
                     grant, conflict, lowest_user, e.grant, e.conflict, e.lowest);
        end
        wait_idle();
    endtask

    task automatic test_diff_func();
        exp_t e;
        set_user(0, 1'b1, 3'd5, 3'd2);
        set_user(1, 1'b1, 3'd1, 3'd1);
        exp_q.push_back('{grant: 4'b0011, conflict: 1'b0, lowest: 3'd1});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || conflict !== e.conflict || lowest_user !== e.lowest) begin
            failures++;
            $display("FAIL diff_func grant=%b conflict=%b lowest=%0d want %b %b %0d",
                     grant, conflict, lowest_user, e.grant, e.conflict, e.lowest);
        end
        req_valid[1] = 1'b0;
        exp_q.push_back('{grant: 4'b0001, conflict: 1'b0, lowest: 3'd5});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || lowest_user !== e.lowest) begin
            failures++;
            $display("FAIL drop_user grant=%b lowest=%0d want %b %0d", grant, lowest_user, e.grant, e.lowest);
        end
        wait_idle();
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   len;
        int   gap;
        logic [3:0] win;
        set_user(0, 1'b1, 3'd3, 3'd1);
        set_user(1, 1'b1, 3'd3, 3'd1);
        exp_q.push_back('{grant: 4'b0001, conflict: 1'b1, lowest: 3'd3});
        exp_q.push_back('{grant: 4'b0010, conflict: 1'b1, lowest: 3'd3});
        exp_q.push_back('{grant: 4'b0001, conflict: 1'b1, lowest: 3'd3});
        tick();
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (grant !== e.grant || lowest_user !== e.lowest) begin
                failures++;
                $display("FAIL rr_winner%0d grant=%b lowest=%0d want %b %0d", k, grant, lowest_user, e.grant, e.lowest);
            end
            win = grant;
            len = 0;
            while (grant === win && win !== 4'b0000 && len < 20) begin
                len++;
                tick();
            end
            checks++;
            if (len != 8) begin
                failures++;
                $display("FAIL rr_hold%0d cycles=%0d want 8", k, len);
            end
            if (k < 2) begin
                gap = 0;
                while (grant === 4'b0000 && gap < 20) begin
                    gap++;
                    tick();
                end
                checks++;
                if (gap != 2) begin
                    failures++;
                    $display("FAIL rr_gap%0d cycles=%0d want 2", k, gap);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_autopilot();
        logic e;
        set_user(0, 1'b1, 3'd7, 3'd5);
        set_user(2, 1'b1, 3'd7, 3'd5);
        for (int k = 0; k < 4; k++) ap_q.push_back(1'b0);
        ap_q.push_back(1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            e = ap_q.pop_front();
            checks++;
            if (autopilot !== e) begin
                failures++;
                $display("FAIL ap_cycle%0d autopilot=%b want %b", k + 1, autopilot, e);
            end
        end
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ap_grant grant=%b busy=%b want 0000 0", grant, busy);
        end
        set_user(2, 1'b1, 3'd6, 3'd5);
        ap_q.push_back(1'b0);
        tick();
        e = ap_q.pop_front();
        checks++;
        if (autopilot !== e) begin
            failures++;
            $display("FAIL ap_exit autopilot=%b want %b", autopilot, e);
        end
        wait_idle();
    endtask

    task automatic test_async_reset();
        set_user(1, 1'b1, 3'd4, 3'd3);
        tick();
        checks++;
        if (busy !== 1'b1 || grant !== 4'b0010 || lowest_user !== 3'd4) begin
            failures++;
            $display("FAIL areset_pre grant=%b busy=%b lowest=%0d want 0010 1 4", grant, busy, lowest_user);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || lowest_user !== 3'd0) begin
            failures++;
            $display("FAIL areset grant=%b busy=%b lowest=%0d want 0", grant, busy, lowest_user);
        end
        tick();
        rst_n = 1'b1;
        wait_idle();
    endtask

    task automatic test_permission();
        set_user(1, 1'b1, 3'd2, 3'd4);
        tick();
`ifdef ARB_PERMISSAO_EN
        checks++;
        if (denied !== 4'b0010 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL perm_denied denied=%b grant=%b want 0010 0000", denied, grant);
        end
        clear_all();
        tick();
        checks++;
        if (denied !== 4'b0000) begin
            failures++;
            $display("FAIL perm_pulse denied=%b want 0000", denied);
        end
`else
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL perm_off grant=%b want 0010", grant);
        end
`endif
        wait_idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_all();
        test_reset();
        test_priority();
        test_diff_func();
        test_round_robin();
        test_autopilot();
        test_permission();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
